// File: rtl/hdu_pkg.sv
`default_nettype none
// ============================================================================
// Package   : hdu_pkg
// Purpose   : Shared HDU types, trace defaults and width helpers.
// Revision  : 1.0
// ============================================================================
package hdu_pkg;

    localparam int TRACE_TS_W   = 32;
    localparam int TRACE_NUM_CH = 4;

    typedef enum logic [1:0] {
        CH_HDR_PARSED = 2'd0,
        CH_DISPATCH   = 2'd1,
        CH_FALLBACK   = 2'd2,
        CH_DONE       = 2'd3
    } trace_ch_e;

    typedef struct packed {
        trace_ch_e               ch_id;
        logic [3:0]              tag;
        logic [TRACE_TS_W-1:0]   ts;
    } trace_rec_t;

    // Never returns 0 so that a single-entry dimension still gets a 1-bit index.
    function automatic int safe_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdu_event_tracer_if.sv
`default_nettype none
// ============================================================================
// Interface : hdu_event_tracer_if
// Purpose   : Single-beat AXI-Stream channel carrying trace records.
// Revision  : 1.0
// ============================================================================
interface hdu_event_tracer_if #(
    parameter int REC_W = 38
) ();

    logic [REC_W-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface
`default_nettype wire

// File: rtl/hdu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module    : hdu_sync_fifo
// Purpose   : First-word-fall-through synchronous FIFO with flush and count.
// Revision  : 1.0
// ============================================================================
module hdu_sync_fifo
    import hdu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = safe_clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic      [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is read straight out of storage; forced to zero when nothing is held.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdu_event_tracer.sv
`default_nettype none
// ============================================================================
// Module    : hdu_event_tracer
// Purpose   : Per-channel event timestamper; stamped records stream out via AXIS.
// Revision  : 1.0
// ============================================================================
module hdu_event_tracer
    import hdu_pkg::*;
#(
    parameter  int NUM_CH = TRACE_NUM_CH,
    parameter  int TAG_W  = 4,
    parameter  int TS_W   = TRACE_TS_W,
    parameter  int DEPTH  = 16,
    localparam int CH_W   = safe_clog2(NUM_CH),
    localparam int REC_W  = CH_W + TAG_W + TS_W,
    localparam int FL_W   = safe_clog2(DEPTH) + 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    enable,
    input  wire logic                    clear,
    input  wire logic [NUM_CH-1:0]       ev_valid,
    input  wire logic [NUM_CH*TAG_W-1:0] ev_tag,
    hdu_event_tracer_if.master           m_axis,
    output logic      [TS_W-1:0]         cycle_count,
    output logic      [FL_W-1:0]         fill_level,
    output logic      [31:0]             drop_count
);

    logic [NUM_CH-1:0]            pend_valid;
    logic [NUM_CH-1:0][TAG_W-1:0] pend_tag;
    logic [NUM_CH-1:0][TS_W-1:0]  pend_ts;
    logic [NUM_CH-1:0]            drop_vec;
    logic [CH_W-1:0]              rr_ptr;
    logic [CH_W-1:0]              grant_idx;
    logic                         grant_any;
    logic                         grant_en;
    logic                         pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [REC_W-1:0]             fifo_head;
    logic [REC_W-1:0]             rec;
    logic [CH_W:0]                n_drops;
    logic [32:0]                  drop_sum;

    assign pop      = m_axis.tvalid && m_axis.tready;
    assign grant_en = grant_any && (!fifo_full || pop) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cycle_count <= '0;
        else if (clear) cycle_count <= '0;
        else            cycle_count <= cycle_count + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             hit;
        logic             granted;
        logic             valid_q;
        logic [TAG_W-1:0] tag_q;
        logic [TS_W-1:0]  ts_q;

        assign hit         = enable && ev_valid[i] && !clear;
        assign granted     = grant_en && (grant_idx == CH_W'(i));
        assign drop_vec[i] = hit && valid_q && !granted;
        assign pend_valid[i] = valid_q;
        assign pend_tag[i]   = tag_q;
        assign pend_ts[i]    = ts_q;

        // A latch being drained this edge may be refilled on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                tag_q   <= '0;
                ts_q    <= '0;
            end else if (clear) begin
                valid_q <= 1'b0;
            end else if (hit && (!valid_q || granted)) begin
                valid_q <= 1'b1;
                tag_q   <= ev_tag[i*TAG_W +: TAG_W];
                ts_q    <= cycle_count;
            end else if (granted) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Round-robin search starting at rr_ptr.
    always_comb begin
        int j;
        j         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!grant_any && pend_valid[CH_W'(j)]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (clear) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        n_drops = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            n_drops = n_drops + (CH_W+1)'(drop_vec[k]);
        end
        drop_sum = {1'b0, drop_count} + 33'(n_drops);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           drop_count <= '0;
        else if (clear)       drop_count <= '0;
        else if (drop_sum[32]) drop_count <= '1;
        else                  drop_count <= drop_sum[31:0];
    end

    assign rec = {grant_idx, pend_tag[grant_idx], pend_ts[grant_idx]};

    hdu_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (grant_en),
        .push_data (rec),
        .pop       (pop && !clear),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill_level)
    );

    assign m_axis.tdata  = fifo_head;
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tlast  = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_hdu_event_tracer.sv
`default_nettype none
// ============================================================================
// Module    : tb_hdu_event_tracer
// Purpose   : Directed self-checking bench for hdu_event_tracer (TS_W=8, DEPTH=4).
// Revision  : 1.0
// ============================================================================
module tb_hdu_event_tracer;
    import hdu_pkg::*;

    localparam int NUM_CH = 4;
    localparam int TAG_W  = 4;
    localparam int TS_W   = 8;
    localparam int DEPTH  = 4;
    localparam int REC_W  = 2 + TAG_W + TS_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    enable;
    logic                    clear;
    logic [NUM_CH-1:0]       ev_valid;
    logic [NUM_CH*TAG_W-1:0] ev_tag;
    logic [TS_W-1:0]         cycle_count;
    logic [2:0]              fill_level;
    logic [31:0]             drop_count;

    int checks = 0;
    int errors = 0;

    hdu_event_tracer_if #(.REC_W(REC_W)) axis ();

    hdu_event_tracer #(
        .NUM_CH (NUM_CH),
        .TAG_W  (TAG_W),
        .TS_W   (TS_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .ev_valid    (ev_valid),
        .ev_tag      (ev_tag),
        .m_axis      (axis),
        .cycle_count (cycle_count),
        .fill_level  (fill_level),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [REC_W-1:0] mk(input int ch, input int tag, input int ts);
        return {2'(ch), 4'(tag), 8'(ts)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
        ev_valid = '0; ev_tag = '0; axis.tready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_count(input int v);
        int n;
        n = 0;
        while (cycle_count !== 8'(v) && n < 300) begin
            tick();
            n++;
        end
        if (cycle_count !== 8'(v)) begin
            checks++; errors++;
            $display("FAIL wait_count: cycle_count=%0d required=%0d", cycle_count, v);
        end
    endtask

    task automatic expect_beat(input logic [REC_W-1:0] exp, input int max_wait, input string name);
        int n;
        n = 0;
        while (axis.tvalid !== 1'b1 && n < max_wait) begin
            tick();
            n++;
        end
        checks++;
        if (axis.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s: tvalid=%b required=1", name, axis.tvalid);
        end else if (axis.tdata !== exp || axis.tlast !== 1'b1) begin
            errors++;
            $display("FAIL %s: tdata=%h tlast=%b required tdata=%h tlast=1",
                     name, axis.tdata, axis.tlast, exp);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
        ev_valid = '0; ev_tag = '0; axis.tready = 1'b1;
        tick(); tick();
        checks++;
        if (cycle_count !== 0 || fill_level !== 0 || drop_count !== 0 ||
            axis.tvalid !== 0 || axis.tdata !== 0 || axis.tlast !== 0) begin
            errors++;
            $display("FAIL reset_values: cnt=%0d fill=%0d drop=%0d tvalid=%b tdata=%h tlast=%b required all 0",
                     cycle_count, fill_level, drop_count, axis.tvalid, axis.tdata, axis.tlast);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cycle_count !== 8'd1) begin
            errors++;
            $display("FAIL reset_first_count: cycle_count=%0d required=1", cycle_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        wait_count(10);
        ev_valid = 4'b0010; ev_tag = 16'h0030;
        tick();
        ev_valid = '0;
        checks++;
        if (axis.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency1: tvalid=%b required=0", axis.tvalid);
        end
        tick();
        checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== mk(int'(CH_DISPATCH), 3, 10) ||
            axis.tlast !== 1'b1 || fill_level !== 3'd1 || drop_count !== 0) begin
            errors++;
            $display("FAIL single_beat: tvalid=%b tdata=%h tlast=%b fill=%0d drop=%0d required 1/%h/1/1/0",
                     axis.tvalid, axis.tdata, axis.tlast, fill_level, drop_count,
                     mk(int'(CH_DISPATCH), 3, 10));
        end
        tick();
        checks++;
        if (axis.tvalid !== 1'b0 || fill_level !== 3'd0) begin
            errors++;
            $display("FAIL single_drained: tvalid=%b fill=%0d required 0/0", axis.tvalid, fill_level);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wait_count(20);
        ev_valid = 4'b1111; ev_tag = 16'h3210;
        tick();
        ev_valid = '0;
        tick();
        for (int c = 0; c < 4; c++) begin
            expect_beat(mk(c, c, 20), 0, $sformatf("simul_ch%0d", c));
        end
        checks++;
        if (axis.tvalid !== 1'b0 || drop_count !== 0) begin
            errors++;
            $display("FAIL simul_end: tvalid=%b drop=%0d required 0/0", axis.tvalid, drop_count);
        end
    endtask

    task automatic test_full();
        do_reset();
        axis.tready = 1'b0;
        wait_count(30);
        ev_valid = 4'b0001; ev_tag = 16'h0005;
        repeat (6) tick();
        ev_valid = '0;
        checks++;
        if (fill_level !== 3'd4 || drop_count !== 32'd1) begin
            errors++;
            $display("FAIL full_level: fill=%0d drop=%0d required 4/1", fill_level, drop_count);
        end
        tick(); tick();
        checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== mk(0, 5, 30) || fill_level !== 3'd4) begin
            errors++;
            $display("FAIL full_hold: tvalid=%b tdata=%h fill=%0d required 1/%h/4",
                     axis.tvalid, axis.tdata, fill_level, mk(0, 5, 30));
        end
        axis.tready = 1'b1;
        for (int t = 30; t <= 34; t++) begin
            expect_beat(mk(0, 5, t), 0, $sformatf("full_drain_ts%0d", t));
        end
        checks++;
        if (axis.tvalid !== 1'b0 || drop_count !== 32'd1) begin
            errors++;
            $display("FAIL full_end: tvalid=%b drop=%0d required 0/1", axis.tvalid, drop_count);
        end
    endtask

    task automatic test_reload();
        do_reset();
        wait_count(40);
        ev_valid = 4'b0100; ev_tag = 16'h0700;
        tick();
        ev_tag = 16'h0900;
        tick();
        ev_valid = '0;
        expect_beat(mk(2, 7, 40), 0, "reload_first");
        expect_beat(mk(2, 9, 41), 0, "reload_second");
        checks++;
        if (drop_count !== 0) begin
            errors++;
            $display("FAIL reload_drop: drop=%0d required=0", drop_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wait_count(255);
        ev_valid = 4'b1000; ev_tag = 16'h1000;
        tick();
        ev_tag = 16'h2000;
        tick();
        ev_valid = '0;
        expect_beat(mk(3, 1, 255), 1, "wrap_255");
        expect_beat(mk(3, 2, 0), 0, "wrap_0");
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b0;
        ev_valid = 4'b1111; ev_tag = 16'hFFFF;
        repeat (3) tick();
        ev_valid = '0;
        tick(); tick();
        checks++;
        if (axis.tvalid !== 1'b0 || fill_level !== 0 || drop_count !== 0) begin
            errors++;
            $display("FAIL enable_low: tvalid=%b fill=%0d drop=%0d required 0/0/0",
                     axis.tvalid, fill_level, drop_count);
        end
        enable = 1'b1;
    endtask

    task automatic test_clear();
        do_reset();
        axis.tready = 1'b0;
        wait_count(50);
        ev_valid = 4'b0111; ev_tag = 16'h0321;
        tick();
        ev_valid = 4'b0010;
        tick();
        ev_valid = '0;
        tick(); tick();
        checks++;
        if (fill_level !== 3'd3 || drop_count !== 32'd1) begin
            errors++;
            $display("FAIL clear_pre: fill=%0d drop=%0d required 3/1", fill_level, drop_count);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (axis.tvalid !== 0 || fill_level !== 0 || cycle_count !== 0 || drop_count !== 0) begin
            errors++;
            $display("FAIL clear_post: tvalid=%b fill=%0d cnt=%0d drop=%0d required 0/0/0/0",
                     axis.tvalid, fill_level, cycle_count, drop_count);
        end
        axis.tready = 1'b1;
        tick(); tick();
        checks++;
        if (axis.tvalid !== 0 || cycle_count !== 8'd2) begin
            errors++;
            $display("FAIL clear_quiet: tvalid=%b cnt=%0d required 0/2", axis.tvalid, cycle_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        axis.tready = 1'b0;
        wait_count(60);
        ev_valid = 4'b0011; ev_tag = 16'h00AB;
        tick();
        ev_valid = '0;
        tick(); tick();
        checks++;
        if (axis.tvalid !== 1'b1 || fill_level !== 3'd2) begin
            errors++;
            $display("FAIL arst_pre: tvalid=%b fill=%0d required 1/2", axis.tvalid, fill_level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (axis.tvalid !== 0 || axis.tdata !== 0 || axis.tlast !== 0 ||
            fill_level !== 0 || cycle_count !== 0 || drop_count !== 0) begin
            errors++;
            $display("FAIL arst_immediate: tvalid=%b tdata=%h tlast=%b fill=%0d cnt=%0d drop=%0d required all 0",
                     axis.tvalid, axis.tdata, axis.tlast, fill_level, cycle_count, drop_count);
        end
        tick();
        rst_n = 1'b1;
        axis.tready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_full();
        test_reload();
        test_wrap();
        test_enable();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
